// File: rtl/lcd_msg_pkg.sv
// Shared constants for the reaction-timer LCD message controller.
// State encoding, message codes, ASCII helpers and fixed 16-char strings.
package lcd_msg_pkg;

    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_CONV  = 3'd2;
    localparam logic [2:0] S_FMT   = 3'd3;
    localparam logic [2:0] S_GO    = 3'd4;
    localparam logic [2:0] S_WBUSY = 3'd5;
    localparam logic [2:0] S_ACK   = 3'd6;

    typedef enum logic [2:0] {
        MSG_REACTION = 3'd0,
        MSG_CHEAT    = 3'd1,
        MSG_SLOW     = 3'd2,
        MSG_WAIT     = 3'd3,
        MSG_TITLE    = 3'd4
    } msg_e;

    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_SP   = 8'h20;
    localparam logic [7:0] ASCII_DASH = 8'h2D;
    localparam logic [7:0] ASCII_DOT  = 8'h2E;
    localparam logic [7:0] ASCII_S    = 8'h73;

    localparam logic [127:0] STR_TITLE = "Reaction Timer  ";
    localparam logic [127:0] STR_CHEAT = "No Cheating!    ";
    localparam logic [127:0] STR_SLOW  = "Too Slow!       ";
    localparam logic [127:0] STR_WAIT  = "Wait for LEDs...";
    localparam logic [39:0]  STR_BEST  = "Best ";

    function automatic msg_e decode_msg(input logic [31:0] sel);
        msg_e m;
        if (sel == 32'd0)      m = MSG_REACTION;
        else if (sel == 32'd1) m = MSG_CHEAT;
        else if (sel == 32'd2) m = MSG_SLOW;
        else if (sel == 32'd3) m = MSG_WAIT;
        else                   m = MSG_TITLE;
        return m;
    endfunction

    function automatic logic [31:0] pow10(input int n);
        logic [31:0] p;
        p = 32'd1;
        for (int i = 0; i < n; i++) p = p * 32'd10;
        return p;
    endfunction

endpackage

// File: rtl/lcd_msg_ctrl_bcd_conv.sv
// Sequential shift-add-3 binary to BCD converter, one bit per cycle.
// Values that do not fit in DIGITS digits are reported as saturated.
module bcd_conv_seq
    import lcd_msg_pkg::*;
#(
    parameter int TIME_W = 10,
    parameter int DIGITS = 4
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                start_i,
    input  logic [TIME_W-1:0]   bin_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                sat_o,
    output logic [4*DIGITS-1:0] bcd_o
);

    localparam int NB0 = (TIME_W * 3) / 10 + 1;
    localparam int NB  = (NB0 > DIGITS) ? NB0 : DIGITS;
    localparam int CW  = $clog2(TIME_W + 1);
    localparam logic [31:0] LIMIT = pow10(DIGITS);

    logic [TIME_W-1:0]        bin_q;
    logic [4*NB-1:0]          bcd_q;
    logic [CW-1:0]            cnt_q;
    logic                     busy_q;
    logic                     sat_q;
    logic [4*NB-1:0]          adj;
    logic [4*NB+TIME_W-1:0]   sh;

    always_comb begin
        adj = bcd_q;
        for (int k = 0; k < NB; k++) begin
            if (adj[4*k +: 4] >= 4'd5)
                adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
        end
        sh = {adj, bin_q} << 1;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            sat_q  <= 1'b0;
        end else if (start_i && !busy_q) begin
            bin_q  <= bin_i;
            bcd_q  <= '0;
            cnt_q  <= CW'(TIME_W);
            busy_q <= 1'b1;
            sat_q  <= (32'(bin_i) >= LIMIT);
        end else if (busy_q) begin
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
            end else begin
                {bcd_q, bin_q} <= sh;
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = busy_q && (cnt_q == '0);
    assign sat_o  = sat_q;
    assign bcd_o  = sat_q ? {DIGITS{4'd9}} : bcd_q[4*DIGITS-1:0];

endmodule

// File: rtl/lcd_msg_ctrl.sv
// Two-line LCD message controller: request handshake, best-time tracking,
// line formatting and a single LcdGo pulse per redraw.
module lcd_msg_ctrl
    import lcd_msg_pkg::*;
#(
    parameter int TIME_W = 10,
    parameter int DIGITS = 4,
    parameter int COLS   = 16,
    parameter int MSG_W  = 2
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [MSG_W-1:0]  MsgSel,
    input  logic [TIME_W-1:0] Value,
    input  logic              Update,
    output logic              Ack,
    input  logic              ClearBest,
    input  logic              LcdBusy,
    output logic              LcdGo,
    output logic [8*COLS-1:0] Line1,
    output logic [8*COLS-1:0] Line2
);

    localparam int LW = 8 * COLS;

    function automatic logic [LW-1:0] fit(input logic [127:0] s);
        logic [LW-1:0] l;
        l = '0;
        for (int i = 0; i < COLS; i++) begin
            if (i < 16) l[LW-1-8*i -: 8] = 8'(s >> (8 * (15 - i)));
            else        l[LW-1-8*i -: 8] = ASCII_SP;
        end
        return l;
    endfunction

    function automatic logic [7:0] dig(input logic dash, input logic [3:0] d);
        return dash ? ASCII_DASH : (ASCII_0 | {4'h0, d});
    endfunction

    // "d.ddd s", optionally behind "Best "; dash form when no best exists
    function automatic logic [LW-1:0] fmt_time(
        input logic                pfx,
        input logic                dash,
        input logic [4*DIGITS-1:0] bcd
    );
        logic [LW-1:0] l;
        logic [7:0]    c;
        int            j;
        l = '0;
        for (int i = 0; i < COLS; i++) begin
            j = pfx ? i - 5 : i;
            c = ASCII_SP;
            if (j < 0)
                c = 8'(STR_BEST >> (8 * (4 - i)));
            else if (j == 0)
                c = dig(dash, 4'(bcd >> (4 * (DIGITS - 1))));
            else if (j == 1)
                c = ASCII_DOT;
            else if (j <= DIGITS)
                c = dig(dash, 4'(bcd >> (4 * (DIGITS - j))));
            else if (j == DIGITS + 2)
                c = ASCII_S;
            l[LW-1-8*i -: 8] = c;
        end
        return l;
    endfunction

    logic [2:0]          state_q, state_d;
    msg_e                msg_q, msg_d, msg_in;
    logic [TIME_W-1:0]   val_q, val_d;
    logic                req_q, req_d;
    logic                skip_q, skip_d;
    logic [TIME_W-1:0]   best_q, best_d;
    logic [4*DIGITS-1:0] best_bcd_q, best_bcd_d;
    logic [LW-1:0]       line1_q, line1_d;
    logic [LW-1:0]       line2_q, line2_d;

    logic                conv_start;
    logic                conv_busy;
    logic                conv_done;
    logic                conv_sat;
    logic [4*DIGITS-1:0] conv_bcd;

    bcd_conv_seq #(
        .TIME_W (TIME_W),
        .DIGITS (DIGITS)
    ) u_conv (
        .Clk     (Clk),
        .Rst     (Rst),
        .start_i (conv_start),
        .bin_i   (val_q),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .sat_o   (conv_sat),
        .bcd_o   (conv_bcd)
    );

    assign msg_in = decode_msg(32'(MsgSel));

    always_comb begin
        state_d    = state_q;
        msg_d      = msg_q;
        val_d      = val_q;
        req_d      = req_q;
        skip_d     = skip_q;
        best_d     = best_q;
        best_bcd_d = best_bcd_q;
        line1_d    = line1_q;
        line2_d    = line2_q;
        conv_start = 1'b0;
        unique case (state_q)
            S_INIT: begin
                req_d   = 1'b0;
                state_d = S_GO;
            end
            S_IDLE: begin
                // a clear wins; a held Update is served on the next pass
                if (ClearBest) begin
                    best_d  = '1;
                    line2_d = fmt_time(1'b1, 1'b1, '0);
                    req_d   = 1'b0;
                    state_d = S_GO;
                end else if (Update) begin
                    msg_d   = msg_in;
                    val_d   = Value;
                    req_d   = 1'b1;
                    state_d = (msg_in == MSG_REACTION) ? S_CONV : S_FMT;
                end
            end
            S_CONV: begin
                conv_start = !conv_busy;
                if (conv_done) state_d = S_FMT;
            end
            S_FMT: begin
                state_d = S_GO;
                unique case (msg_q)
                    MSG_REACTION: begin
                        line1_d = fmt_time(1'b0, 1'b0, conv_bcd);
                        if (val_q < best_q) begin
                            best_d     = val_q;
                            best_bcd_d = conv_bcd;
                            line2_d    = fmt_time(1'b1, 1'b0, conv_bcd);
                        end else begin
                            line2_d = fmt_time(1'b1, &best_q, best_bcd_q);
                        end
                    end
                    MSG_CHEAT: line1_d = fit(STR_CHEAT);
                    MSG_SLOW:  line1_d = fit(STR_SLOW);
                    MSG_WAIT:  line1_d = fit(STR_WAIT);
                    default:   line1_d = fit(STR_TITLE);
                endcase
            end
            S_GO: begin
                if (!LcdBusy) begin
                    skip_d  = 1'b1;
                    state_d = S_WBUSY;
                end
            end
            S_WBUSY: begin
                // LcdBusy only rises a cycle after LcdGo, so ignore one cycle
                if (skip_q)
                    skip_d = 1'b0;
                else if (!LcdBusy)
                    state_d = req_q ? S_ACK : S_IDLE;
            end
            S_ACK: begin
                if (!Update) state_d = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= S_INIT;
            msg_q      <= MSG_TITLE;
            val_q      <= '0;
            req_q      <= 1'b0;
            skip_q     <= 1'b0;
            best_q     <= '1;
            best_bcd_q <= '0;
            line1_q    <= fit(STR_TITLE);
            line2_q    <= fmt_time(1'b1, 1'b1, '0);
        end else begin
            state_q    <= state_d;
            msg_q      <= msg_d;
            val_q      <= val_d;
            req_q      <= req_d;
            skip_q     <= skip_d;
            best_q     <= best_d;
            best_bcd_q <= best_bcd_d;
            line1_q    <= line1_d;
            line2_q    <= line2_d;
        end
    end

    assign Ack   = (state_q == S_ACK);
    assign LcdGo = (state_q == S_GO) && !LcdBusy;
    assign Line1 = line1_q;
    assign Line2 = line2_q;

endmodule

// File: tb/tb_lcd_msg_ctrl.sv
// Bench for lcd_msg_ctrl: a TIME_W=10 and a TIME_W=14 instance against a
// string-level model of the two display lines and the handshake.
module tb_lcd_msg_ctrl;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic         rst0 = 1'b1, rst1 = 1'b1;
    logic [1:0]   sel0 = '0, sel1 = '0;
    logic [9:0]   val0 = '0;
    logic [13:0]  val1 = '0;
    logic         upd0 = 1'b0, upd1 = 1'b0;
    logic         clr0 = 1'b0, clr1 = 1'b0;
    logic         busy0 = 1'b0, busy1 = 1'b0;
    logic         bf1 = 1'b0;
    logic         ack0, ack1, go0, go1;
    logic [127:0] l1_0, l2_0, l1_1, l2_1;

    int gocnt0 = 0, gocnt1 = 0, lc0 = 0, lc1 = 0;
    int checks = 0, errors = 0;
    int best_m [2];
    int none_v [2] = '{1023, 16383};
    int gobase [2];
    logic [127:0] e1 [2];
    logic [127:0] e2 [2];
    logic chk [2] = '{1'b0, 1'b0};
    logic ackp0 = 1'b0, ackp1 = 1'b0;

    lcd_msg_ctrl #(.TIME_W(10), .DIGITS(4), .COLS(16), .MSG_W(2)) u0 (
        .Clk(Clk), .Rst(rst0), .MsgSel(sel0), .Value(val0),
        .Update(upd0), .Ack(ack0), .ClearBest(clr0),
        .LcdBusy(busy0), .LcdGo(go0), .Line1(l1_0), .Line2(l2_0)
    );

    lcd_msg_ctrl #(.TIME_W(14), .DIGITS(4), .COLS(16), .MSG_W(2)) u1 (
        .Clk(Clk), .Rst(rst1), .MsgSel(sel1), .Value(val1),
        .Update(upd1), .Ack(ack1), .ClearBest(clr1),
        .LcdBusy(busy1), .LcdGo(go1), .Line1(l1_1), .Line2(l2_1)
    );

    // LCD interface models: busy for 3 cycles after each LcdGo
    always begin
        @(negedge Clk);
        busy0 = (lc0 > 0);
        if (lc0 > 0) lc0--;
        #1;
        if (go0 === 1'b1) begin gocnt0++; lc0 = 3; end
    end

    always begin
        @(negedge Clk);
        busy1 = bf1 || (lc1 > 0);
        if (lc1 > 0) lc1--;
        #1;
        if (go1 === 1'b1) begin gocnt1++; lc1 = 3; end
    end

    task automatic chk128(string nm, logic [127:0] got, logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=\"%s\" exp=\"%s\"", nm, got, exp);
        end
    endtask

    task automatic chkint(string nm, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    function automatic string tstr(int v);
        int s;
        s = (v > 9999) ? 9999 : v;
        return $sformatf("%0d.%03d s", s / 1000, s % 1000);
    endfunction

    function automatic logic [127:0] pad(string s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++)
            r[127-8*i -: 8] = (i < s.len()) ? s[i] : 8'h20;
        return r;
    endfunction

    function automatic logic [127:0] l2m(int b);
        if (b < 0) return pad("Best -.--- s");
        return pad({"Best ", tstr(b)});
    endfunction

    function automatic logic [127:0] msgm(int sel);
        case (sel)
            1:       return pad("No Cheating!");
            2:       return pad("Too Slow!");
            3:       return pad("Wait for LEDs...");
            default: return pad("Reaction Timer");
        endcase
    endfunction

    function automatic logic get_go(int d);
        return (d != 0) ? go1 : go0;
    endfunction

    function automatic logic get_ack(int d);
        return (d != 0) ? ack1 : ack0;
    endfunction

    function automatic int get_cnt(int d);
        return (d != 0) ? gocnt1 : gocnt0;
    endfunction

    task automatic model_req(int d, int sel, int v);
        if (sel == 0) begin
            e1[d] = pad(tstr(v));
            if ((best_m[d] < 0) ? (v < none_v[d]) : (v < best_m[d]))
                best_m[d] = v;
            e2[d] = l2m(best_m[d]);
        end else begin
            e1[d] = msgm(sel);
        end
    endtask

    // single compare process: lines whenever Ack is up or idle checks are on
    always begin
        @(negedge Clk);
        #1;
        if (ack0 === 1'b1 || chk[0]) begin
            chk128("u0_line1", l1_0, e1[0]);
            chk128("u0_line2", l2_0, e2[0]);
        end
        if (ack0 === 1'b1 && !ackp0)
            chkint("u0_go_before_ack", gocnt0 - gobase[0], 1);
        ackp0 = (ack0 === 1'b1);
        if (ack1 === 1'b1 || chk[1]) begin
            chk128("u1_line1", l1_1, e1[1]);
            chk128("u1_line2", l2_1, e2[1]);
        end
        if (ack1 === 1'b1 && !ackp1)
            chkint("u1_go_before_ack", gocnt1 - gobase[1], 1);
        ackp1 = (ack1 === 1'b1);
    end

    task automatic rst_pulse(int d);
        @(posedge Clk); #2;
        if (d == 0) begin rst0 = 1'b1; upd0 = 1'b0; clr0 = 1'b0; end
        else        begin rst1 = 1'b1; upd1 = 1'b0; clr1 = 1'b0; end
        @(posedge Clk); #2;
        if (d == 0) rst0 = 1'b0; else rst1 = 1'b0;
        best_m[d] = -1;
        e1[d] = pad("Reaction Timer");
        e2[d] = l2m(-1);
        gobase[d] = get_cnt(d);
        @(negedge Clk); #1;
        chkint("rst_ack", int'(get_ack(d)), 0);
        chkint("rst_go", int'(get_go(d)), 0);
        chk128("rst_line1", (d != 0) ? l1_1 : l1_0, "Reaction Timer  ");
        chk128("rst_line2", (d != 0) ? l2_1 : l2_0, "Best -.--- s    ");
        repeat (10) @(posedge Clk);
        chkint("rst_one_go", get_cnt(d) - gobase[d], 1);
    endtask

    task automatic req(int d, int sel, int v, int lat);
        int  n;
        logic seen;
        @(posedge Clk); #2;
        model_req(d, sel, v);
        gobase[d] = get_cnt(d);
        if (d == 0) begin sel0 = 2'(sel); val0 = 10'(v); upd0 = 1'b1; end
        else        begin sel1 = 2'(sel); val1 = 14'(v); upd1 = 1'b1; end
        seen = 1'b0;
        for (n = 1; n <= 300; n++) begin
            @(posedge Clk); @(negedge Clk); #1;
            if (get_go(d) === 1'b1) begin seen = 1'b1; break; end
        end
        if (lat > 0) chkint("latency", seen ? n : -1, lat);
        else         chkint("go_seen", int'(seen), 1);
        n = 0;
        while (get_ack(d) !== 1'b1 && n < 50) begin
            @(negedge Clk); #1; n++;
        end
        chkint("ack_rise", int'(get_ack(d) === 1'b1), 1);
        repeat (2) @(posedge Clk);
        #2;
        if (d == 0) upd0 = 1'b0; else upd1 = 1'b0;
        n = 0;
        do begin
            @(negedge Clk); #1; n++;
        end while (get_ack(d) !== 1'b0 && n < 10);
        chkint("ack_fall", int'(get_ack(d) === 1'b1), 0);
        chkint("one_go", get_cnt(d) - gobase[d], 1);
    endtask

    initial begin
        int g;
        int anyack;
        rst_pulse(0);
        rst_pulse(1);

        req(0, 0, 250, 14);
        chk128("r250_l1", l1_0, "0.250 s         ");
        chk128("r250_l2", l2_0, "Best 0.250 s    ");
        req(0, 0, 300, 14);
        chk128("r300_l1", l1_0, "0.300 s         ");
        chk128("r300_l2", l2_0, "Best 0.250 s    ");
        req(0, 1, 0, 2);
        chk128("cheat_l1", l1_0, "No Cheating!    ");
        chk128("cheat_l2", l2_0, "Best 0.250 s    ");
        req(0, 2, 0, 2);
        req(0, 3, 0, 2);
        req(0, 0, 1023, 14);
        chk128("r1023_l1", l1_0, "1.023 s         ");
        req(0, 0, 5, 14);
        chk128("r5_l2", l2_0, "Best 0.005 s    ");

        // reset while the converter is running
        @(posedge Clk); #2;
        gobase[0] = gocnt0;
        sel0 = 2'd0; val0 = 10'd500; upd0 = 1'b1;
        repeat (6) @(posedge Clk);
        chkint("conv_no_go", gocnt0 - gobase[0], 0);
        rst_pulse(0);
        req(0, 0, 400, 14);
        chk128("r400_l2", l2_0, "Best 0.400 s    ");

        // ClearBest in idle: redraw with dashes, no Ack
        @(posedge Clk); #2;
        g = gocnt0;
        clr0 = 1'b1;
        best_m[0] = -1;
        e2[0] = l2m(-1);
        @(posedge Clk); #2;
        clr0 = 1'b0;
        anyack = 0;
        repeat (12) begin
            @(negedge Clk); #1;
            if (ack0 !== 1'b0) anyack++;
        end
        chkint("clr_no_ack", anyack, 0);
        chkint("clr_one_go", gocnt0 - g, 1);
        chk128("clr_l1", l1_0, "0.400 s         ");
        chk128("clr_l2", l2_0, "Best -.--- s    ");
        chk[0] = 1'b1;
        repeat (3) @(posedge Clk);
        chk[0] = 1'b0;

        // wide instance: saturation and a stalled LCD interface
        @(posedge Clk); #2;
        bf1 = 1'b1;
        @(posedge Clk);
        g = gocnt1;
        fork
            req(1, 0, 12000, 0);
            begin
                repeat (22) @(posedge Clk);
                #2;
                chkint("stall_no_go", gocnt1 - g, 0);
                bf1 = 1'b0;
            end
        join
        chk128("sat_l1", l1_1, "9.999 s         ");
        chk128("sat_l2", l2_1, "Best 9.999 s    ");
        req(1, 0, 1234, 18);
        chk128("w1234_l1", l1_1, "1.234 s         ");
        chk128("w1234_l2", l2_1, "Best 1.234 s    ");
        req(1, 0, 10000, 18);
        chk128("w10000_l1", l1_1, "9.999 s         ");
        chk128("w10000_l2", l2_1, "Best 1.234 s    ");
        req(1, 3, 0, 2);

        repeat (5) @(posedge Clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
